// File: rtl/sha_digest_writeback.sv
// sha_digest_writeback: captures a finished SHA digest and writes it to data
// memory as DIGEST_W/WORD_W words, most-significant word first, starting at a
// runtime base address. Uses a ready/valid write handshake and has a one-deep
// pending-digest slot, a done pulse and an overrun pulse.
// Optional build macro: SHA_WB_BYTESWAP_EN (byte-reverse each written word).
module sha_digest_writeback #(
  parameter int unsigned DIGEST_W  = 256,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DIGEST_W-1:0] digest_in,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  localparam int unsigned NWORDS = DIGEST_W / WORD_W;
  localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGEST_W-1:0] dig_q, dig_d;
  logic                pend_v_q, pend_v_d;
  logic [DIGEST_W-1:0] pend_dig_q, pend_dig_d;
  logic [ADDR_W-1:0]   pend_base_q, pend_base_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;

  // Select word i of a digest (word 0 is the most-significant) and apply the
  // optional byte reversal for little-endian memory images.
  function automatic logic [WORD_W-1:0] word_of(input logic [DIGEST_W-1:0] d,
                                                 input logic [IDX_W-1:0]    i);
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] r;
    w = '0;
    for (int unsigned k = 0; k < NWORDS; k++) begin
      if (i == IDX_W'(k)) w = d[DIGEST_W-1-k*WORD_W -: WORD_W];
    end
`ifdef SHA_WB_BYTESWAP_EN
    r = '0;
    for (int unsigned b = 0; b < WORD_W/8; b++) begin
      r[8*b +: 8] = w[WORD_W-8-8*b +: 8];
    end
`else
    r = w;
`endif
    return r;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dig_d       = dig_q;
    pend_v_d    = pend_v_q;
    pend_dig_d  = pend_dig_q;
    pend_base_d = pend_base_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          // Drain the pending slot; a same-cycle start refills it.
          dig_d       = pend_dig_q;
          idx_d       = '0;
          state_d     = WRITE;
          mem_we_d    = 1'b1;
          mem_addr_d  = pend_base_q;
          mem_wdata_d = word_of(pend_dig_q, '0);
          pend_v_d    = start;
          if (start) begin
            pend_dig_d  = digest_in;
            pend_base_d = base_addr;
          end
        end else if (start) begin
          dig_d       = digest_in;
          idx_d       = '0;
          state_d     = WRITE;
          mem_we_d    = 1'b1;
          mem_addr_d  = base_addr;
          mem_wdata_d = word_of(digest_in, '0);
        end
      end
      WRITE: begin
        mem_we_d = 1'b1;
        if (mem_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d  = DONE;
            mem_we_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            idx_d       = idx_q + IDX_W'(1);
            mem_addr_d  = mem_addr_q + STEP;
            mem_wdata_d = word_of(dig_q, idx_q + IDX_W'(1));
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        mem_we_d = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        mem_we_d = 1'b0;
      end
    endcase

    // Requests arriving while a transfer is in flight go to the slot or are dropped.
    if (start && (state_q != IDLE)) begin
      if (!pend_v_q) begin
        pend_v_d    = 1'b1;
        pend_dig_d  = digest_in;
        pend_base_d = base_addr;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE) || pend_v_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      dig_q       <= '0;
      pend_v_q    <= 1'b0;
      pend_dig_q  <= '0;
      pend_base_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dig_q       <= dig_d;
      pend_v_q    <= pend_v_d;
      pend_dig_q  <= pend_dig_d;
      pend_base_q <= pend_base_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sha_digest_writeback.sv
// Self-checking bench for sha_digest_writeback (default parameters).
// Basic write-back is table driven; backpressure, pending/overrun, address wrap,
// mid-burst reset and byte order are hand-written sequences.
module tb_sha_digest_writeback;

  logic          clk;
  logic          reset;
  logic          start;
  logic [255:0]  digest_in;
  logic [31:0]   base_addr;
  logic          mem_ready;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  sha_digest_writeback #(
    .DIGEST_W (256),
    .WORD_W   (32),
    .ADDR_W   (32),
    .ADDR_STEP(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .digest_in(digest_in),
    .base_addr(base_addr),
    .mem_ready(mem_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        st;
    logic        rdy;
    logic [31:0] base;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_done;
    logic        e_ovr;
    logic        e_busy;
  } vec_t;

  vec_t tbl[11];

  // Digests with a recognisable value in each word (word 0 is the top word).
  localparam logic [255:0] DIG_N = {32'h1, 32'h2, 32'h3, 32'h4,
                                    32'h5, 32'h6, 32'h7, 32'h8};
  localparam logic [255:0] DIG_A = {32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004,
                                    32'hA0000005, 32'hA0000006, 32'hA0000007, 32'hA0000008};
  localparam logic [255:0] DIG_B = {32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004,
                                    32'hB0000005, 32'hB0000006, 32'hB0000007, 32'hB0000008};
  localparam logic [255:0] DIG_C = {32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004,
                                    32'hC0000005, 32'hC0000006, 32'hC0000007, 32'hC0000008};

  // Expected memory image of a word, accounting for the byte-swap build.
  function automatic logic [31:0] ew(input logic [31:0] w);
`ifdef SHA_WB_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input logic we, input logic [31:0] addr,
                            input logic [31:0] data, input logic dn, input logic ov,
                            input logic bz, input logic chk_ad);
    chk({nm, ".we"},      32'(mem_we),  32'(we));
    chk({nm, ".done"},    32'(done),    32'(dn));
    chk({nm, ".overrun"}, 32'(overrun), 32'(ov));
    chk({nm, ".busy"},    32'(busy),    32'(bz));
    if (chk_ad) begin
      chk({nm, ".addr"},  mem_addr,  addr);
      chk({nm, ".wdata"}, mem_wdata, data);
    end
  endtask

  // Run with mem_ready high until busy drops, bounded.
  task automatic drain(input string nm);
    int n;
    n = 0;
    start     = 1'b0;
    mem_ready = 1'b1;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk({nm, ".drain_timeout"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Basic write-back, one row per clock.
    tbl[0] = '{1'b1, 1'b0, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h100, ew(32'h1), 1'b0, 1'b0, 1'b1};
    for (int i = 2; i <= 8; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h100 + 32'(4*(i-1)), ew(32'(i)),
                 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h11C, ew(32'h8), 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h11C, ew(32'h8), 1'b0, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; digest_in = '0; base_addr = '0; mem_ready = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 11; i++) begin
      reset     = tbl[i].rst;
      start     = tbl[i].st;
      mem_ready = tbl[i].rdy;
      base_addr = tbl[i].base;
      digest_in = DIG_N;
      tick();
      expect_out($sformatf("basic[%0d]", i), tbl[i].e_we, tbl[i].e_addr, tbl[i].e_data,
                 tbl[i].e_done, tbl[i].e_ovr, tbl[i].e_busy, 1'b1);
    end
    start = 1'b0;

    // Backpressure: hold mem_ready low for 3 cycles while word 3 is presented.
    base_addr = 32'h100; digest_in = DIG_N; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      // n is the cycle index relative to the start cycle
      logic [31:0] w;
      w = (n <= 4) ? 32'(n - 1) : (n <= 7) ? 32'd3 : 32'(n - 4);
      if (n <= 11)
        expect_out($sformatf("bp[%0d]", n), 1'b1, 32'h100 + 4*w, ew(w + 1), 1'b0, 1'b0, 1'b1, 1'b1);
      else if (n == 12)
        expect_out("bp.done", 1'b0, 32'h11C, ew(32'h8), 1'b1, 1'b0, 1'b1, 1'b1);
      else
        expect_out("bp.idle", 1'b0, 32'h11C, ew(32'h8), 1'b0, 1'b0, 1'b0, 1'b1);
      mem_ready = !(n >= 4 && n <= 6);
      tick();
    end
    drain("bp");

    // Pending and overrun: A at T, B at T+2 (held), C at T+4 (dropped).
    mem_ready = 1'b1;
    digest_in = DIG_A; base_addr = 32'h200; start = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      int n;
      tick();
      n = c + 1;
      if (n >= 1 && n <= 8)
        expect_out($sformatf("pend.A[%0d]", n), 1'b1, 32'h200 + 32'(4*(n-1)),
                   ew(32'hA0000000 + 32'(n)), 1'b0, n == 5, 1'b1, 1'b1);
      else if (n == 9)
        expect_out("pend.doneA", 1'b0, 32'h21C, ew(32'hA0000008), 1'b1, 1'b0, 1'b1, 1'b1);
      else if (n == 10)
        expect_out("pend.gap", 1'b0, 32'h21C, ew(32'hA0000008), 1'b0, 1'b0, 1'b1, 1'b1);
      else if (n >= 11 && n <= 18)
        expect_out($sformatf("pend.B[%0d]", n), 1'b1, 32'h300 + 32'(4*(n-11)),
                   ew(32'hB0000000 + 32'(n-10)), 1'b0, 1'b0, 1'b1, 1'b1);
      else if (n == 19)
        expect_out("pend.doneB", 1'b0, 32'h31C, ew(32'hB0000008), 1'b1, 1'b0, 1'b1, 1'b1);
      else
        expect_out($sformatf("pend.noC[%0d]", n), 1'b0, 32'h31C, ew(32'hB0000008),
                   1'b0, 1'b0, 1'b0, 1'b1);
      start = 1'b0;
      if (n == 2) begin start = 1'b1; digest_in = DIG_B; base_addr = 32'h300; end
      if (n == 4) begin start = 1'b1; digest_in = DIG_C; base_addr = 32'h400; end
    end
    start = 1'b0;

    // Address wrap past 2^32.
    digest_in = DIG_N; base_addr = 32'hFFFFFFF8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      logic [31:0] ea;
      case (n)
        1: ea = 32'hFFFFFFF8;
        2: ea = 32'hFFFFFFFC;
        default: ea = 32'(4*(n-3));
      endcase
      expect_out($sformatf("wrap[%0d]", n), 1'b1, ea, ew(32'(n)), 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
    end
    drain("wrap");

    // Mid-burst reset with a digest sitting in the pending slot.
    digest_in = DIG_A; base_addr = 32'h500; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 6; n++) begin
      start = (n == 2);
      digest_in = DIG_B; base_addr = 32'h600;
      tick();
    end
    start = 1'b0;
    expect_out("rst.word5", 1'b1, 32'h514, ew(32'hA0000006), 1'b0, 1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    tick();
    expect_out("rst.cleared", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      expect_out($sformatf("rst.quiet[%0d]", n), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    digest_in = DIG_C; base_addr = 32'h700; start = 1'b1;
    tick();
    start = 1'b0;
    expect_out("rst.restart", 1'b1, 32'h700, ew(32'hC0000001), 1'b0, 1'b0, 1'b1, 1'b1);
    for (int n = 2; n <= 9; n++) tick();
    expect_out("rst.restart_done", 1'b0, 32'h71C, ew(32'hC0000008), 1'b1, 1'b0, 1'b1, 1'b1);
    drain("rst");

    // Byte order of word 0.
    digest_in = {32'h11223344, 224'h0}; base_addr = 32'h800; start = 1'b1;
    tick();
    start = 1'b0;
`ifdef SHA_WB_BYTESWAP_EN
    chk("bswap.word0", mem_wdata, 32'h44332211);
`else
    chk("bswap.word0", mem_wdata, 32'h11223344);
`endif
    drain("bswap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
